pixel_readout_capture: RTL and testbench

PIXEL_READOUT_CAPTURE -- requirements
Module: pixel_readout_capture

---
 rtl/pixel_readout_capture.sv | 176 +++++++++++++++++
 tb/tb_pixel_readout_capture.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_readout_capture.sv
// rtl/pixel_readout_capture.sv - two-row pixel readout capture with 4-word pixel stream
// Optional feature macro: READOUT_FRAME_COUNTER_EN adds the Frame_count output.
module pixel_readout_capture #(
  parameter int DATA_W = 8
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Erase,
  input  logic              Expose,
  input  logic              NRE_1,
  input  logic              NRE_2,
  input  logic              ADC,
  input  logic [DATA_W-1:0] ADC_1_data,
  input  logic [DATA_W-1:0] ADC_2_data,
  output logic [DATA_W-1:0] Pix_data,
  output logic              Pix_valid,
  input  logic              Pix_ready,
  output logic              Pix_last,
  output logic              Frame_err
`ifdef READOUT_FRAME_COUNTER_EN
  ,
  output logic [7:0]        Frame_count
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ARMED  = 3'd1,
    EXPOSE = 3'd2,
    READ   = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_next;
  logic              adc_q;
  logic              expose_q;
  logic              row1_done;
  logic              row2_done;
  logic [DATA_W-1:0] r1c1;
  logic [DATA_W-1:0] r1c2;
  logic [DATA_W-1:0] r2c1;
  logic [DATA_W-1:0] r2c2;
  logic [1:0]        idx;

  logic              adc_fall;
  logic              cap_row1;
  logic              cap_row2;
  logic              cap_conflict;
  logic              xfer;
  logic              frame_done;

  // State register; everything else follows from state and the registered datapath.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode, capture qualifiers and the combinational stream outputs.
  always_comb begin
    state_next   = state;
    adc_fall     = adc_q & ~ADC;
    cap_row1     = 1'b0;
    cap_row2     = 1'b0;
    cap_conflict = 1'b0;
    Pix_valid    = 1'b0;
    Pix_last     = 1'b0;
    Pix_data     = '0;

    // Erase wins over a same-cycle capture, so captures are qualified with !Erase.
    if (state == READ && !Erase && adc_fall) begin
      cap_row1     = !NRE_1 &&  NRE_2;
      cap_row2     =  NRE_1 && !NRE_2;
      cap_conflict = !NRE_1 && !NRE_2;
    end

    if (state == DRAIN) begin
      Pix_valid = 1'b1;
      Pix_last  = (idx == 2'd3);
      case (idx)
        2'd0:    Pix_data = r1c1;
        2'd1:    Pix_data = r1c2;
        2'd2:    Pix_data = r2c1;
        default: Pix_data = r2c2;
      endcase
    end

    xfer       = Pix_valid & Pix_ready;
    frame_done = xfer & Pix_last;

    case (state)
      IDLE: begin
        if (Erase) state_next = ARMED;
      end
      ARMED: begin
        if (Expose && !Erase) state_next = EXPOSE;
      end
      EXPOSE: begin
        if (Erase)                    state_next = ARMED;
        else if (expose_q && !Expose) state_next = READ;
      end
      READ: begin
        if (Erase)                       state_next = ARMED;
        else if (row1_done && row2_done) state_next = DRAIN;
      end
      DRAIN: begin
        if (frame_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Edge registers, row slots, drain pointer and the sticky error flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      adc_q     <= 1'b0;
      expose_q  <= 1'b0;
      row1_done <= 1'b0;
      row2_done <= 1'b0;
      r1c1      <= '0;
      r1c2      <= '0;
      r2c1      <= '0;
      r2c2      <= '0;
      idx       <= 2'd0;
      Frame_err <= 1'b0;
    end else begin
      adc_q    <= ADC;
      expose_q <= Expose;

      if (Erase && state != DRAIN) begin
        row1_done <= 1'b0;
        row2_done <= 1'b0;
      end else if (frame_done) begin
        row1_done <= 1'b0;
        row2_done <= 1'b0;
      end else begin
        // A repeated capture of a row simply overwrites its slots.
        if (cap_row1) begin
          r1c1      <= ADC_1_data;
          r1c2      <= ADC_2_data;
          row1_done <= 1'b1;
        end
        if (cap_row2) begin
          r2c1      <= ADC_1_data;
          r2c2      <= ADC_2_data;
          row2_done <= 1'b1;
        end
      end

      if (state != DRAIN) begin
        idx <= 2'd0;
      end else if (xfer) begin
        idx <= idx + 2'd1;
      end

      if (cap_conflict || (state == DRAIN && Erase)) begin
        Frame_err <= 1'b1;
      end
    end
  end

`ifdef READOUT_FRAME_COUNTER_EN
  // Completed-frame counter, wraps naturally at 8 bits.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Frame_count <= 8'd0;
    end else if (frame_done) begin
      Frame_count <= Frame_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pixel_readout_capture.sv
// tb/tb_pixel_readout_capture.sv - scoreboard bench for pixel_readout_capture
module tb_pixel_readout_capture;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Erase = 1'b0;
  logic       Expose = 1'b0;
  logic       NRE_1 = 1'b1;
  logic       NRE_2 = 1'b1;
  logic       ADC = 1'b0;
  logic [7:0] ADC_1_data = 8'd0;
  logic [7:0] ADC_2_data = 8'd0;
  logic [7:0] Pix_data;
  logic       Pix_valid;
  logic       Pix_ready = 1'b1;
  logic       Pix_last;
  logic       Frame_err;
`ifdef READOUT_FRAME_COUNTER_EN
  logic [7:0] Frame_count;
`endif

  int tests = 0;
  int fails = 0;
  logic [8:0] exp_q[$];

  pixel_readout_capture #(.DATA_W(8)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Erase      (Erase),
    .Expose     (Expose),
    .NRE_1      (NRE_1),
    .NRE_2      (NRE_2),
    .ADC        (ADC),
    .ADC_1_data (ADC_1_data),
    .ADC_2_data (ADC_2_data),
    .Pix_data   (Pix_data),
    .Pix_valid  (Pix_valid),
    .Pix_ready  (Pix_ready),
    .Pix_last   (Pix_last),
    .Frame_err  (Frame_err)
`ifdef READOUT_FRAME_COUNTER_EN
    ,
    .Frame_count(Frame_count)
`endif
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every valid cycle must show the scoreboard head; a handshake pops it.
  always @(negedge Clk) begin
    if (!Reset && Pix_valid === 1'b1) begin
      check("stream_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        check("pix_data", 32'(Pix_data), 32'(exp_q[0][7:0]));
        check("pix_last", 32'(Pix_last), 32'(exp_q[0][8]));
        if (Pix_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1; Erase = 1'b0; Expose = 1'b0; NRE_1 = 1'b1; NRE_2 = 1'b1; ADC = 1'b0;
    Pix_ready = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic do_erase();
    Erase = 1'b1; tick(); Erase = 1'b0; tick();
  endtask

  task automatic do_expose();
    Expose = 1'b1;
    repeat (5) tick();
    Expose = 1'b0;
    tick(); tick();
  endtask

  // row: 0 both NRE high, 1 row1, 2 row2, 3 both NRE low
  task automatic capture(input int row, input logic [7:0] d1, input logic [7:0] d2);
    NRE_1 = !(row == 1 || row == 3);
    NRE_2 = !(row == 2 || row == 3);
    ADC_1_data = d1; ADC_2_data = d2;
    ADC = 1'b1; tick();
    ADC = 1'b0; tick();
    NRE_1 = 1'b1; NRE_2 = 1'b1;
    tick();
  endtask

  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b0, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_drain_done"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_valid_drop"}, 32'(Pix_valid), 32'd0);
  endtask

  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    do_erase();
    do_expose();
    push4(a, b, c, d);
    capture(1, a, b);
    capture(2, c, d);
    wait_drain("frame");
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_valid", 32'(Pix_valid), 32'd0);
    check("rst_last",  32'(Pix_last),  32'd0);
    check("rst_data",  32'(Pix_data),  32'd0);
    check("rst_err",   32'(Frame_err), 32'd0);

    // Nominal frame
    do_erase();
    do_expose();
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    capture(1, 8'h11, 8'h22);
    check("nom_no_early_valid", 32'(Pix_valid), 32'd0);
    capture(2, 8'h33, 8'h44);
    check("nom_latency_valid", 32'(Pix_valid), 32'd1);
    wait_drain("nom");
    check("nom_err", 32'(Frame_err), 32'd0);

    // Backpressure on r1c2
    do_erase();
    do_expose();
    push4(8'h5a, 8'h22, 8'h7e, 8'h81);
    capture(1, 8'h5a, 8'h22);
    capture(2, 8'h7e, 8'h81);
    tick();
    Pix_ready = 1'b0;
    repeat (3) begin
      check("bp_hold_data", 32'(Pix_data), 32'h22);
      check("bp_hold_valid", 32'(Pix_valid), 32'd1);
      tick();
    end
    check("bp_hold_data4", 32'(Pix_data), 32'h22);
    Pix_ready = 1'b1;
    wait_drain("bp");

    // Both NRE low discards the sample and flags an error
    do_erase();
    do_expose();
    capture(3, 8'hde, 8'had);
    check("conf_err", 32'(Frame_err), 32'd1);
    capture(2, 8'h33, 8'h44);
    tick();
    check("conf_no_row1", 32'(Pix_valid), 32'd0);
    push4(8'h55, 8'h66, 8'h33, 8'h44);
    capture(1, 8'h55, 8'h66);
    wait_drain("conf");
    check("conf_err_sticky", 32'(Frame_err), 32'd1);

    // Erase during READ drops the captured row
    do_reset();
    do_erase();
    do_expose();
    capture(1, 8'haa, 8'hbb);
    do_erase();
    do_expose();
    capture(2, 8'hc3, 8'hd4);
    tick();
    check("erase_read_cleared", 32'(Pix_valid), 32'd0);
    push4(8'h01, 8'h02, 8'hc3, 8'hd4);
    capture(1, 8'h01, 8'h02);
    wait_drain("erase_read");

    // ADC fall outside READ is ignored
    do_erase();
    capture(1, 8'hee, 8'hff);
    do_expose();
    capture(2, 8'h10, 8'h20);
    tick();
    check("adc_outside_read", 32'(Pix_valid), 32'd0);
    push4(8'h30, 8'h40, 8'h10, 8'h20);
    capture(1, 8'h30, 8'h40);
    wait_drain("adc_outside");
    check("adc_outside_err", 32'(Frame_err), 32'd0);

    // Erase during DRAIN: error set, frame delivered intact
    do_erase();
    do_expose();
    push4(8'h91, 8'h92, 8'h93, 8'h94);
    capture(1, 8'h91, 8'h92);
    capture(2, 8'h93, 8'h94);
    Pix_ready = 1'b0;
    Erase = 1'b1; tick(); Erase = 1'b0;
    check("erase_drain_err", 32'(Frame_err), 32'd1);
    check("erase_drain_valid", 32'(Pix_valid), 32'd1);
    Pix_ready = 1'b1;
    wait_drain("erase_drain");

    // Reset after two words in DRAIN aborts the frame
    do_erase();
    do_expose();
    push4(8'ha1, 8'ha2, 8'ha3, 8'ha4);
    capture(1, 8'ha1, 8'ha2);
    capture(2, 8'ha3, 8'ha4);
    tick();
    tick();
    check("rst_mid_words_left", 32'(exp_q.size()), 32'd2);
    Pix_ready = 1'b0;
    Reset = 1'b1;
    tick();
    check("rst_mid_valid", 32'(Pix_valid), 32'd0);
    check("rst_mid_data",  32'(Pix_data),  32'd0);
    check("rst_mid_last",  32'(Pix_last),  32'd0);
    check("rst_mid_err",   32'(Frame_err), 32'd0);
    Reset = 1'b0;
    exp_q.delete();
    Pix_ready = 1'b1;
    repeat (3) begin
      tick();
      check("rst_mid_quiet", 32'(Pix_valid), 32'd0);
    end

`ifdef READOUT_FRAME_COUNTER_EN
    do_reset();
    check("cnt_rst", 32'(Frame_count), 32'd0);
    for (int f = 0; f < 257; f++) begin
      run_frame(8'(f), 8'(f + 1), 8'(f + 2), 8'(f + 3));
      if (f == 0) check("cnt_one", 32'(Frame_count), 32'd1);
    end
    check("cnt_wrap", 32'(Frame_count), 32'd1);
`else
    run_frame(8'h12, 8'h34, 8'h56, 8'h78);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
